// File: rtl/muu_value_put_if.sv
// Handshake bundle for muu_value_put: value-write command in, framed value beats in,
// memory write command and packed line stream out, plus error pulses and line counter.
interface muu_value_put_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LEN_WIDTH    = 12,
  parameter int MEMORY_WIDTH = 512
);
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [LEN_WIDTH-1:0]    cmd_len;
  logic                    cmd_drop;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [63:0]             val_data;
  logic                    val_last;
  logic                    val_valid;
  logic                    val_ready;
  logic [ADDR_WIDTH-1:0]   wr_cmd_addr;
  logic [LEN_WIDTH-3:0]    wr_cmd_lines;
  logic                    wr_cmd_valid;
  logic                    wr_cmd_ready;
  logic [MEMORY_WIDTH-1:0] wr_data;
  logic                    wr_data_last;
  logic                    wr_data_valid;
  logic                    wr_data_ready;
  logic                    err_short;
  logic                    err_long;
  logic [31:0]             lines_written;

  modport slave (
    input  cmd_addr, cmd_len, cmd_drop, cmd_valid,
    output cmd_ready,
    input  val_data, val_last, val_valid,
    output val_ready,
    output wr_cmd_addr, wr_cmd_lines, wr_cmd_valid,
    input  wr_cmd_ready,
    output wr_data, wr_data_last, wr_data_valid,
    input  wr_data_ready,
    output err_short, err_long, lines_written
  );

  modport master (
    output cmd_addr, cmd_len, cmd_drop, cmd_valid,
    input  cmd_ready,
    output val_data, val_last, val_valid,
    input  val_ready,
    input  wr_cmd_addr, wr_cmd_lines, wr_cmd_valid,
    output wr_cmd_ready,
    input  wr_data, wr_data_last, wr_data_valid,
    output wr_data_ready,
    input  err_short, err_long, lines_written
  );
endinterface

// File: rtl/muu_value_put.sv
// Value write path: issues one memory write command per value, then packs 64-bit
// value beats eight at a time into memory lines, padding short streams and draining long ones.
module muu_value_put #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LEN_WIDTH    = 12,
  parameter int MEMORY_WIDTH = 512
) (
  input logic           clk,
  input logic           rst,
  muu_value_put_if.slave bus
);
  localparam int LANES = MEMORY_WIDTH / 64;
  localparam int CW    = LEN_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, CMD, FILL, PAD, LONG_WAIT, DRAIN} state_t;

  state_t                  state;
  logic [2:0]              idx;
  logic [CW-1:0]           remaining;
  logic [CW-1:0]           lines_left;
  logic [LANES-1:0][63:0]  buffer;
  logic [LANES-1:0][63:0]  line_next;
  logic [CW-1:0]           acc_words;
  logic [CW-1:0]           acc_lines;
  logic [CW-1:0]           rem_next;
  logic                    close_line;
  logic                    beat_fire;
  logic                    data_free;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.val_ready = ((state == FILL) && !bus.wr_data_valid) || (state == DRAIN);
  assign beat_fire     = bus.val_valid && bus.val_ready;
  assign data_free     = !bus.wr_data_valid || bus.wr_data_ready;

  // Sizes use one extra bit so a maximum-length value cannot overflow the rounding.
  always_comb begin
    acc_words      = (CW'(bus.cmd_len) + CW'(7)) >> 3;
    acc_lines      = (acc_words + CW'(7)) >> 3;
    line_next      = buffer;
    line_next[idx] = bus.val_data;
    rem_next       = remaining - CW'(1);
    close_line     = (idx == 3'(LANES - 1)) || (rem_next == '0) || bus.val_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      idx               <= '0;
      remaining         <= '0;
      lines_left        <= '0;
      buffer            <= '0;
      bus.wr_cmd_addr   <= '0;
      bus.wr_cmd_lines  <= '0;
      bus.wr_cmd_valid  <= 1'b0;
      bus.wr_data       <= '0;
      bus.wr_data_last  <= 1'b0;
      bus.wr_data_valid <= 1'b0;
      bus.err_short     <= 1'b0;
      bus.err_long      <= 1'b0;
      bus.lines_written <= '0;
    end else begin
      bus.err_short <= 1'b0;
      bus.err_long  <= 1'b0;
      if (bus.wr_data_valid && bus.wr_data_ready) begin
        bus.wr_data_valid <= 1'b0;
        bus.wr_data_last  <= 1'b0;
        bus.lines_written <= bus.lines_written + 32'd1;
      end

      case (state)
        IDLE: begin
          if (bus.cmd_valid && (bus.cmd_len != '0)) begin
            if (bus.cmd_drop) begin
              state <= DRAIN;
            end else begin
              bus.wr_cmd_addr  <= ADDR_WIDTH'(bus.cmd_addr);
              bus.wr_cmd_lines <= acc_lines[LEN_WIDTH-3:0];
              bus.wr_cmd_valid <= 1'b1;
              remaining        <= acc_words;
              lines_left       <= acc_lines;
              idx              <= '0;
              buffer           <= '0;
              state            <= CMD;
            end
          end
        end

        CMD: begin
          if (bus.wr_cmd_ready) begin
            bus.wr_cmd_valid <= 1'b0;
            state            <= FILL;
          end
        end

        // Beats are only taken while the output slot is empty, so a close never collides with a pending line.
        FILL: begin
          if (beat_fire) begin
            remaining <= rem_next;
            if (close_line) begin
              bus.wr_data       <= MEMORY_WIDTH'(line_next);
              bus.wr_data_valid <= 1'b1;
              lines_left        <= lines_left - CW'(1);
              buffer            <= '0;
              idx               <= '0;
              if (rem_next == '0) begin
                bus.wr_data_last <= 1'b1;
                if (!bus.val_last) begin
                  bus.err_long <= 1'b1;
                  state        <= LONG_WAIT;
                end else begin
                  state <= IDLE;
                end
              end else if (bus.val_last) begin
                bus.err_short    <= 1'b1;
                bus.wr_data_last <= (lines_left == CW'(1));
                state            <= (lines_left == CW'(1)) ? IDLE : PAD;
              end else begin
                bus.wr_data_last <= 1'b0;
              end
            end else begin
              buffer[idx] <= bus.val_data;
              idx         <= idx + 3'd1;
            end
          end
        end

        PAD: begin
          if (data_free) begin
            bus.wr_data       <= '0;
            bus.wr_data_valid <= 1'b1;
            bus.wr_data_last  <= (lines_left == CW'(1));
            lines_left        <= lines_left - CW'(1);
            if (lines_left == CW'(1)) state <= IDLE;
          end
        end

        LONG_WAIT: begin
          if (data_free) state <= DRAIN;
        end

        DRAIN: begin
          if (beat_fire && bus.val_last) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muu_value_put.sv
// Self-checking bench for muu_value_put: directed vector table, randomized values against
// a transaction-level packing model, and a reset-during-fill sequence.
module tb_muu_value_put;
  localparam int BUDGET = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] exp_lw = '0;

  always #5 clk = ~clk;

  muu_value_put_if #(.ADDR_WIDTH(32), .LEN_WIDTH(12), .MEMORY_WIDTH(512)) vbus ();

  muu_value_put #(.ADDR_WIDTH(32), .LEN_WIDTH(12), .MEMORY_WIDTH(512)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vbus)
  );

  typedef struct {
    int          len;
    bit          drop;
    int          nbeats;
    int          bp;
    logic [63:0] base;
    int          exp_cmd_lines;
    int          exp_short;
    int          exp_long;
  } vec_t;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one value through the DUT and compares against a packing model built from the size rules.
  task automatic applyStimulus(input string tag, input int len, input bit drop, input int nbeats,
                               input int bp, input bit rnd, input logic [63:0] base,
                               input int exp_cmd_lines, input int exp_short, input int exp_long);
    logic [63:0]  beats[$];
    logic [511:0] exp_q[$];
    logic [511:0] got_q[$];
    bit           last_q[$];
    logic [511:0] line, prev_data;
    logic [31:0]  addr, got_addr;
    int           words, lines, used, cmd_cnt, got_lines_f, cmd_cyc, first_cyc;
    int           es, el, stab_err, vr_err, hold, quiet;
    bit           drv_done, drv_to, mon_done, stalled, prev_last;

    addr = $urandom;
    for (int i = 0; i < nbeats; i++)
      beats.push_back(rnd ? {$urandom, $urandom} : base + 64'(i));
    words = (len + 7) / 8;
    lines = (words + 7) / 8;
    used  = (nbeats < words) ? nbeats : words;
    if (len > 0 && !drop) begin
      for (int j = 0; j < lines; j++) begin
        line = '0;
        for (int i = 0; i < 8; i++)
          if (j * 8 + i < used) line[64*i +: 64] = beats[j * 8 + i];
        exp_q.push_back(line);
      end
    end

    cmd_cnt = 0; got_lines_f = -1; got_addr = '0; cmd_cyc = -1; first_cyc = -1;
    es = 0; el = 0; stab_err = 0; vr_err = 0; hold = 0; quiet = 0;
    drv_done = 0; drv_to = 0; mon_done = 0; stalled = 0; prev_last = 0; prev_data = '0;

    fork
      begin
        bit acc;
        int t;
        vbus.cmd_addr  = addr;
        vbus.cmd_len   = 12'(len);
        vbus.cmd_drop  = drop;
        vbus.cmd_valid = 1'b1;
        t = 0;
        do begin
          acc = vbus.cmd_ready;
          @(negedge clk);
          t++;
        end while (!acc && t < BUDGET);
        if (!acc) drv_to = 1;
        vbus.cmd_valid = 1'b0;
        for (int b = 0; b < nbeats && !drv_to; b++) begin
          vbus.val_data  = beats[b];
          vbus.val_last  = (b == nbeats - 1);
          vbus.val_valid = 1'b1;
          t = 0;
          do begin
            acc = vbus.val_ready;
            @(negedge clk);
            t++;
          end while (!acc && t < BUDGET);
          if (!acc) drv_to = 1;
        end
        vbus.val_valid = 1'b0;
        vbus.val_last  = 1'b0;
        drv_done = 1;
      end
      begin
        for (int c = 0; c < BUDGET; c++) begin
          vbus.wr_cmd_ready = (bp == 0) ? 1'b1 : (c % 3 == 2);
          if (vbus.wr_cmd_valid && vbus.wr_cmd_ready) begin
            cmd_cnt++;
            cmd_cyc     = c;
            got_addr    = vbus.wr_cmd_addr;
            got_lines_f = int'(vbus.wr_cmd_lines);
          end
          if (stalled && (!vbus.wr_data_valid || vbus.wr_data !== prev_data || vbus.wr_data_last !== prev_last))
            stab_err++;
          if (vbus.wr_data_valid && vbus.val_ready) vr_err++;
          if (vbus.wr_data_valid) hold++;
          vbus.wr_data_ready = (bp == 0) || (hold > bp);
          if (vbus.wr_data_valid && vbus.wr_data_ready) begin
            got_q.push_back(vbus.wr_data);
            last_q.push_back(vbus.wr_data_last);
            if (first_cyc < 0) first_cyc = c;
            hold    = 0;
            stalled = 0;
          end else begin
            stalled   = vbus.wr_data_valid;
            prev_data = vbus.wr_data;
            prev_last = vbus.wr_data_last;
          end
          if (vbus.err_short) es++;
          if (vbus.err_long)  el++;
          if (drv_done && got_q.size() >= exp_q.size()) quiet++;
          @(negedge clk);
          if (quiet >= 4) begin
            mon_done = 1;
            break;
          end
        end
        vbus.wr_cmd_ready  = 1'b0;
        vbus.wr_data_ready = 1'b0;
      end
    join

    checkOutput({tag, " completed"}, {drv_to, mon_done}, 2'b01);
    if (exp_cmd_lines < 0) begin
      checkOutput({tag, " no_wr_cmd"}, 512'(cmd_cnt), 0);
    end else begin
      checkOutput({tag, " wr_cmd_count"}, 512'(cmd_cnt), 1);
      checkOutput({tag, " wr_cmd_lines"}, 512'(got_lines_f), 512'(exp_cmd_lines));
      checkOutput({tag, " wr_cmd_addr"}, 512'(got_addr), 512'(addr));
      if (exp_q.size() > 0)
        checkOutput({tag, " cmd_before_data"}, 512'(cmd_cyc < first_cyc), 1);
    end
    checkOutput({tag, " line_count"}, 512'(got_q.size()), 512'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      checkOutput($sformatf("%s line%0d", tag, j), got_q[j], exp_q[j]);
      checkOutput($sformatf("%s last%0d", tag, j), 512'(last_q[j]), 512'(j == exp_q.size() - 1));
    end
    checkOutput({tag, " err_short"}, 512'(es), 512'(exp_short));
    checkOutput({tag, " err_long"}, 512'(el), 512'(exp_long));
    checkOutput({tag, " stable_under_bp"}, 512'(stab_err), 0);
    checkOutput({tag, " val_ready_gated"}, 512'(vr_err), 0);
    exp_lw = exp_lw + 32'(exp_q.size());
    checkOutput({tag, " lines_written"}, 512'(vbus.lines_written), 512'(exp_lw));
    checkOutput({tag, " back_idle"}, 512'(vbus.cmd_ready), 1);
  endtask

  initial begin
    vec_t vecs[$];
    int   len, words, nbeats, mode, es, el, cl;
    bit   drop;

    vbus.cmd_addr = '0; vbus.cmd_len = '0; vbus.cmd_drop = 1'b0; vbus.cmd_valid = 1'b0;
    vbus.val_data = '0; vbus.val_last = 1'b0; vbus.val_valid = 1'b0;
    vbus.wr_cmd_ready = 1'b0; vbus.wr_data_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset cmd_ready", 512'(vbus.cmd_ready), 1);
    checkOutput("reset val_ready", 512'(vbus.val_ready), 0);
    checkOutput("reset wr_cmd_valid", 512'(vbus.wr_cmd_valid), 0);
    checkOutput("reset wr_data_valid", 512'(vbus.wr_data_valid), 0);
    checkOutput("reset wr_data", vbus.wr_data, '0);
    checkOutput("reset errs", 512'({vbus.err_short, vbus.err_long, vbus.wr_data_last}), 0);
    checkOutput("reset lines_written", 512'(vbus.lines_written), 0);
    rst = 1'b0;
    @(negedge clk);

    //            len   drop nbeats bp  base        cmd_lines short long
    vecs.push_back('{64,   0,  8,    0,  64'h0,       1,        0,    0});
    vecs.push_back('{20,   0,  3,    0,  64'hA0,      1,        0,    0});
    vecs.push_back('{130,  0,  17,   5,  64'h1000,    3,        0,    0});
    vecs.push_back('{64,   0,  4,    0,  64'h2000,    1,        1,    0});
    vecs.push_back('{8,    0,  4,    0,  64'h3000,    1,        0,    1});
    vecs.push_back('{40,   1,  5,    0,  64'h4000,   -1,        0,    0});
    vecs.push_back('{0,    0,  0,    0,  64'h0,      -1,        0,    0});
    vecs.push_back('{200,  0,  10,   2,  64'h5000,    4,        1,    0});
    vecs.push_back('{4095, 0,  512,  0,  64'h6000,    64,       0,    0});
    vecs.push_back('{72,   0,  9,    1,  64'h7000,    2,        0,    0});
    for (int v = 0; v < vecs.size(); v++)
      applyStimulus($sformatf("vec%0d", v), vecs[v].len, vecs[v].drop, vecs[v].nbeats, vecs[v].bp,
                    1'b0, vecs[v].base, vecs[v].exp_cmd_lines, vecs[v].exp_short, vecs[v].exp_long);

    for (int r = 0; r < 25; r++) begin
      len   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 300));
      drop  = ($urandom_range(0, 7) == 0);
      words = (len + 7) / 8;
      mode  = int'($urandom_range(0, 3));
      if (len == 0)                   nbeats = 0;
      else if (mode == 0 && words > 1) nbeats = int'($urandom_range(1, words - 1));
      else if (mode == 1)              nbeats = words + int'($urandom_range(1, 4));
      else                             nbeats = words;
      cl = (len == 0 || drop) ? -1 : (words + 7) / 8;
      es = (cl >= 0 && nbeats < words) ? 1 : 0;
      el = (cl >= 0 && nbeats > words) ? 1 : 0;
      applyStimulus($sformatf("rnd%0d", r), len, drop, nbeats, int'($urandom_range(0, 3)),
                    1'b1, 64'h0, cl, es, el);
    end

    // Reset while the line buffer holds three beats of a one-line value.
    vbus.cmd_addr = 32'h55; vbus.cmd_len = 12'd64; vbus.cmd_drop = 1'b0; vbus.cmd_valid = 1'b1;
    vbus.wr_cmd_ready = 1'b1;
    @(negedge clk);
    vbus.cmd_valid = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      vbus.val_data = 64'hBEEF_0000 + 64'(b); vbus.val_last = 1'b0; vbus.val_valid = 1'b1;
      @(negedge clk);
    end
    vbus.val_valid = 1'b0;
    vbus.wr_cmd_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst cmd_ready", 512'(vbus.cmd_ready), 1);
    checkOutput("midrst val_ready", 512'(vbus.val_ready), 0);
    checkOutput("midrst outputs", 512'({vbus.wr_cmd_valid, vbus.wr_data_valid, vbus.wr_data_last,
                                        vbus.err_short, vbus.err_long}), 0);
    checkOutput("midrst lines_written", 512'(vbus.lines_written), 0);
    rst = 1'b0;
    vbus.wr_data_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrst no_partial_line", 512'(vbus.wr_data_valid), 0);
    checkOutput("midrst lines_written_held", 512'(vbus.lines_written), 0);
    vbus.wr_data_ready = 1'b0;
    exp_lw = '0;
    applyStimulus("after_reset", 8, 1'b0, 1, 0, 1'b0, 64'h9999, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
